alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameters SHALL be: ID, default 0, CDB slot index reported on cdb_id; XLEN, default 32, operand/result width (power of 2, >=8); TAG_WIDTH, default 6, destination tag width; STAGES, default 2, pipeline depth (>=1).
REQ-002 Ports SHALL be, in order (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all in-flight and incoming ops
- in_valid  in  1  issue request from RS
- in_ctrl  in  4  operation code
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B
- in_tag  in  TAG_WIDTH  destination tag
- in_ready  out  1  unit can accept an op this cycle
- cdb_req  out  1  result valid, requesting CDB
- cdb_grant  in  1  CDB arbiter grant for this unit, same cycle as cdb_req
- cdb_data  out  XLEN  result
- cdb_tag  out  TAG_WIDTH  destination tag of result
- cdb_excp  out  1  exception flag of result
- cdb_id  out  $clog2(ID+2)  constant ID
- occupancy  out  $clog2(STAGES+1)  number of valid stages

Function
REQ-003 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU (unsigned), 15 EXC; codes 10-14 SHALL give result 0, excp 0.
- ADD/SUB wrap modulo 2^XLEN.
- Shifts use only in_b[$clog2(XLEN)-1:0]; SRA sign-fills.
- SLT/SLTU result is 1 or 0, zero-extended to XLEN.
- EXC: result 0, excp 1; all other codes excp 0.
REQ-004 Result SHALL be computed combinationally from inputs and captured in stage 1; stages 2..STAGES SHALL carry valid, data, tag, excp unchanged; stage STAGES drives the cdb_* outputs directly from registers.
REQ-005 An op SHALL be accepted at a rising edge iff in_valid & in_ready & ~flush.
REQ-006 Last stage SHALL advance iff cdb_grant or it is empty; stage k<STAGES SHALL advance iff stage k+1 is empty or advancing (bubble collapse); in_ready SHALL equal stage-1 advance condition, combinational, no dependency on in_valid.
REQ-007 A stage that advances with no incoming valid op SHALL become empty; a stage that does not advance SHALL hold all fields.
REQ-008 cdb_grant while cdb_req=0 SHALL be ignored; cdb_req SHALL stay high with stable data/tag/excp until granted.
REQ-009 Latency: op accepted at edge t with no back-pressure SHALL raise cdb_req in the cycle after edge t+STAGES-1; sustained throughput SHALL be 1 op/cycle when cdb_grant is held high.
REQ-010 Flush at an edge SHALL clear every valid bit and drop any concurrent input; flush SHALL take priority over grant and accept; data/tag fields need not be cleared.
REQ-011 occupancy SHALL equal the count of valid stages, registered-state derived, range 0..STAGES.
REQ-012 cdb_id SHALL be the constant ID at all times, including reset.
REQ-013 Ordering SHALL be preserved: results leave in acceptance order; no op is duplicated or lost except by flush/rst.

Reset
REQ-014 rst high at an edge SHALL clear all valid bits and zero all data, tag and excp registers; rst SHALL dominate flush, accept and grant.
REQ-015 After reset: cdb_req=0, cdb_data=0, cdb_tag=0, cdb_excp=0, occupancy=0, in_ready=1.
REQ-016 rst asserted mid-operation SHALL discard all in-flight ops with no CDB request in the cycle after the reset edge.

Verification
REQ-017 STAGES=2, grant tied 1: ADD a=0xFFFFFFFF b=1 tag=5 -> cdb_req 2nd cycle after accept, data=0, tag=5, excp=0.
REQ-018 SLT a=0xFFFFFFFF b=0 -> data=1; SLTU same operands -> data=0; SRA a=0x80000000 b=0x21 -> data=0xC0000000; code 15 -> data=0, excp=1.
REQ-019 Grant held 0, issue 3 ops back-to-back: in_ready drops after STAGES ops accepted, occupancy=2, cdb outputs stable; raise grant -> results exit in order, one per cycle, third op accepted same cycle as first grant.
REQ-020 Pipeline full, assert flush with in_valid=1 -> next cycle occupancy=0, cdb_req=0, in_ready=1, flushed-cycle input never appears on CDB.
REQ-021 rst asserted with 2 ops in flight and flush=1, grant=1 -> next cycle all outputs at REQ-015 values.
REQ-022 STAGES=1, XLEN=64: SLL a=1 b=0x7F -> data=0x8000000000000000, cdb_req the cycle after accept.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined integer ALU that issues results onto a common data bus (CDB).
// Stages collapse bubbles and hold under CDB back-pressure; flush squashes everything in flight.
module alu_pipe #(
  parameter int ID        = 0,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6,
  parameter int STAGES    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [3:0]                   in_ctrl,
  input  logic [XLEN-1:0]              in_a,
  input  logic [XLEN-1:0]              in_b,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         in_ready,
  output logic                         cdb_req,
  input  logic                         cdb_grant,
  output logic [XLEN-1:0]              cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic                         cdb_excp,
  output logic [$clog2(ID+2)-1:0]      cdb_id,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int ID_W  = $clog2(ID + 2);
  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_EXC  = 4'd15;

  // Returns {excp, result}; reserved codes fall through to zero.
  function automatic logic [XLEN:0] alu_eval(
    input logic [3:0]      ctrl,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SH_W-1:0] sh;
    logic [XLEN-1:0] r;
    logic            e;
    sh = b[SH_W-1:0];
    r  = '0;
    e  = 1'b0;
    case (ctrl)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_EXC:  e = 1'b1;
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  logic                 excp_p0;
  logic [XLEN-1:0]      res_p0;

  logic [STAGES-1:0]    vld_p;
  logic [XLEN-1:0]      data_p [STAGES];
  logic [TAG_WIDTH-1:0] tag_p  [STAGES];
  logic                 excp_p [STAGES];
  logic [STAGES-1:0]    adv;

  // Stage 0: combinational evaluation of the incoming op
  assign {excp_p0, res_p0} = alu_eval(in_ctrl, in_a, in_b);

  // A stage moves when any stage at or beyond it has a hole, or the CDB takes the head.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = cdb_grant;
      for (int j = k; j < STAGES; j++) begin
        if (!vld_p[j]) adv[k] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];

  // Stage 1: capture the evaluated result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p[0]  <= 1'b0;
      data_p[0] <= '0;
      tag_p[0]  <= '0;
      excp_p[0] <= 1'b0;
    end else if (adv[0]) begin
      vld_p[0]  <= in_valid & ~flush;
      data_p[0] <= res_p0;
      tag_p[0]  <= in_tag;
      excp_p[0] <= excp_p0;
    end else if (flush) begin
      vld_p[0]  <= 1'b0;
    end
  end

  // Stages 2..STAGES: carry the result forward unchanged
  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p[k]  <= 1'b0;
        data_p[k] <= '0;
        tag_p[k]  <= '0;
        excp_p[k] <= 1'b0;
      end else if (adv[k]) begin
        vld_p[k]  <= vld_p[k-1] & ~flush;
        data_p[k] <= data_p[k-1];
        tag_p[k]  <= tag_p[k-1];
        excp_p[k] <= excp_p[k-1];
      end else if (flush) begin
        vld_p[k]  <= 1'b0;
      end
    end
  end

  // Output: last stage registers drive the CDB directly
  assign cdb_req   = vld_p[STAGES-1];
  assign cdb_data  = data_p[STAGES-1];
  assign cdb_tag   = tag_p[STAGES-1];
  assign cdb_excp  = excp_p[STAGES-1];
  assign cdb_id    = ID_W'(ID);
  assign occupancy = OCC_W'($countones(vld_p));

endmodule
